// File: rtl/modexp_controller.sv
// Right-to-left square-and-multiply sequencer computing base^exponent mod modulus
// by issuing one request at a time to an external `modular` reduction unit.
module modexp_controller #(
   parameter int OP_W  = 16,
   parameter int NUM_W = 2 * OP_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [OP_W-1:0]  base,
   input  logic [OP_W-1:0]  exponent,
   input  logic [OP_W-1:0]  modulus,
   output logic             busy,
   output logic             done,
   output logic             error,
   output logic [OP_W-1:0]  result,
   output logic             mod_ready,
   output logic [NUM_W-1:0] mod_numerator,
   output logic [NUM_W-1:0] mod_denominator,
   input  logic             mod_done,
   input  logic [NUM_W-1:0] mod_result
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SCAN,
      S_REQ,
      S_WAIT,
      S_REL,
      S_FINISH
   } state_t;

   typedef enum logic [1:0] {
      OP_BASE,
      OP_MUL,
      OP_SQR
   } op_t;

   state_t          state;
   op_t             op;
   logic [OP_W-1:0] e;
   logic [OP_W-1:0] n;
   logic [OP_W-1:0] b;
   logic [OP_W-1:0] acc;

   logic [NUM_W-1:0] mul_prod;
   logic [NUM_W-1:0] sqr_prod;
   logic [OP_W-1:0]  reduced;
   logic             unused_hi;

   // acc and b are always below n, so both products fit without truncation
   assign mul_prod  = NUM_W'(acc) * NUM_W'(b);
   assign sqr_prod  = NUM_W'(b) * NUM_W'(b);
   assign reduced   = mod_result[OP_W-1:0];
   assign unused_hi = ^mod_result[NUM_W-1:OP_W];

   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= S_IDLE;
         op              <= OP_BASE;
         e               <= '0;
         n               <= '0;
         b               <= '0;
         acc             <= '0;
         busy            <= 1'b0;
         done            <= 1'b0;
         error           <= 1'b0;
         result          <= '0;
         mod_ready       <= 1'b0;
         mod_numerator   <= '0;
         mod_denominator <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  e     <= exponent;
                  n     <= modulus;
                  b     <= base;
                  acc   <= (modulus == OP_W'(1)) ? '0 : OP_W'(1);
                  busy  <= 1'b1;
                  error <= 1'b0;
                  // Division by zero is reported without touching the modular unit
                  if (modulus == '0) begin
                     error  <= 1'b1;
                     result <= '0;
                     done   <= 1'b1;
                     state  <= S_FINISH;
                  end else begin
                     op    <= OP_BASE;
                     state <= S_REQ;
                  end
               end
            end
            S_SCAN: begin
               if (e == '0) begin
                  result <= acc;
                  done   <= 1'b1;
                  state  <= S_FINISH;
               end else begin
                  op    <= e[0] ? OP_MUL : OP_SQR;
                  state <= S_REQ;
               end
            end
            S_REQ: begin
               case (op)
                  OP_MUL:  mod_numerator <= mul_prod;
                  OP_SQR:  mod_numerator <= sqr_prod;
                  default: mod_numerator <= NUM_W'(b);
               endcase
               mod_denominator <= NUM_W'(n);
               mod_ready       <= 1'b1;
               state           <= S_WAIT;
            end
            S_WAIT: begin
               if (mod_done) begin
                  // Clearing e[0] after a multiply lets the next scan square the same bit
                  case (op)
                     OP_MUL: begin
                        acc <= reduced;
                        e   <= {e[OP_W-1:1], 1'b0};
                     end
                     OP_SQR: begin
                        b <= reduced;
                        e <= e >> 1;
                     end
                     default: b <= reduced;
                  endcase
                  mod_ready <= 1'b0;
                  state     <= S_REL;
               end
            end
            S_REL: begin
               if (!mod_done) begin
                  state <= S_SCAN;
               end
            end
            S_FINISH: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_modexp_controller.sv
// Bench for modexp_controller: a latency-randomised modular unit model, a table of
// known cases, multi-cycle corner sequences and random operands against a reference.
module tb_modexp_controller;

   localparam int OP_W  = 16;
   localparam int NUM_W = 2 * OP_W;

   logic             clk = 1'b0;
   logic             reset;
   logic             start;
   logic [OP_W-1:0]  base;
   logic [OP_W-1:0]  exponent;
   logic [OP_W-1:0]  modulus;
   logic             busy;
   logic             done;
   logic             error;
   logic [OP_W-1:0]  result;
   logic             mod_ready;
   logic [NUM_W-1:0] mod_numerator;
   logic [NUM_W-1:0] mod_denominator;
   logic             mod_done = 1'b0;
   logic [NUM_W-1:0] mod_result = '0;

   int checks = 0;
   int errors = 0;
   int req_count = 0;

   modexp_controller #(.OP_W(OP_W), .NUM_W(NUM_W)) dut (
      .clk             (clk),
      .reset           (reset),
      .start           (start),
      .base            (base),
      .exponent        (exponent),
      .modulus         (modulus),
      .busy            (busy),
      .done            (done),
      .error           (error),
      .result          (result),
      .mod_ready       (mod_ready),
      .mod_numerator   (mod_numerator),
      .mod_denominator (mod_denominator),
      .mod_done        (mod_done),
      .mod_result      (mod_result)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input longint actual, input longint expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
      end
   endtask

   // Behavioural modular unit: random 1-20 cycle latency, done held until ready drops
   logic             model_busy = 1'b0;
   int               model_cnt  = 0;
   logic [NUM_W-1:0] model_num  = '0;
   always @(posedge clk) begin
      if (reset || !mod_ready) begin
         mod_done   <= 1'b0;
         model_busy <= 1'b0;
      end else if (!model_busy && !mod_done) begin
         model_busy <= 1'b1;
         model_cnt  <= $urandom_range(0, 19);
         model_num  <= mod_numerator;
      end else if (model_busy) begin
         if (model_cnt == 0) begin
            checkOutput("operand_stable", mod_numerator, model_num);
            mod_result <= (mod_denominator != '0) ? mod_numerator % mod_denominator : '0;
            mod_done   <= 1'b1;
            model_busy <= 1'b0;
         end else begin
            model_cnt <= model_cnt - 1;
         end
      end
   end

   // Counts requests as rising edges of mod_ready
   logic ready_q = 1'b0;
   always @(negedge clk) begin
      if (mod_ready && !ready_q) req_count++;
      ready_q = mod_ready;
   end

   function automatic longint refModexp(input logic [OP_W-1:0] b, input logic [OP_W-1:0] e,
                                        input logic [OP_W-1:0] m);
      longint unsigned r, x, mm;
      if (m == 0) return 0;
      mm = longint'(m);
      r  = 1 % mm;
      x  = longint'(b) % mm;
      for (int i = 0; i < OP_W; i++) begin
         if (e[i]) r = (r * x) % mm;
         x = (x * x) % mm;
      end
      return longint'(r);
   endfunction

   function automatic int refReqs(input logic [OP_W-1:0] e, input logic [OP_W-1:0] m);
      int bitlen = 0;
      if (m == 0) return 0;
      for (int i = 0; i < OP_W; i++) if (e[i]) bitlen = i + 1;
      return 1 + $countones(e) + ((bitlen > 1) ? bitlen - 1 : 0);
   endfunction

   task automatic applyStimulus(input logic [OP_W-1:0] b, input logic [OP_W-1:0] e,
                                input logic [OP_W-1:0] m);
      @(negedge clk);
      base     = b;
      exponent = e;
      modulus  = m;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic waitDone(output logic [OP_W-1:0] r, output logic er, output int cycles);
      bit seen = 0;
      cycles = 0;
      for (int i = 0; i < 5000; i++) begin
         if (done) begin
            seen = 1;
            break;
         end
         @(negedge clk);
         cycles++;
      end
      checkOutput("done_timeout", seen, 1);
      r  = result;
      er = error;
      @(negedge clk);
      checkOutput("done_pulse_width", {done, busy}, 2'b00);
   endtask

   task automatic runTransaction(input string name, input logic [OP_W-1:0] b,
                                 input logic [OP_W-1:0] e, input logic [OP_W-1:0] m,
                                 input longint exp_r, input logic exp_er, input int exp_reqs);
      logic [OP_W-1:0] r;
      logic            er;
      int              cycles;
      int              req_base = req_count;
      applyStimulus(b, e, m);
      checkOutput({name, "_busy"}, busy, 1);
      waitDone(r, er, cycles);
      checkOutput({name, "_result"}, r, exp_r);
      checkOutput({name, "_error"}, er, exp_er);
      checkOutput({name, "_requests"}, req_count - req_base, exp_reqs);
   endtask

   typedef struct {
      string           name;
      logic [OP_W-1:0] b;
      logic [OP_W-1:0] e;
      logic [OP_W-1:0] m;
      longint          exp_r;
      logic            exp_er;
      int              exp_reqs;
   } vec_t;

   vec_t vecs[6];

   initial begin
      logic [OP_W-1:0] r, b, e, m;
      logic            er;
      int              cycles, req_base;
      bit              saw_done;

      vecs[0] = '{"pow_4_13_497", 16'd4,   16'd13, 16'd497, 445, 1'b0, 7};
      vecs[1] = '{"prereduce",    16'd100, 16'd2,  16'd7,   4,   1'b0, 3};
      vecs[2] = '{"exp0",         16'd3,   16'd0,  16'd7,   1,   1'b0, 1};
      vecs[3] = '{"exp0_mod1",    16'd9,   16'd0,  16'd1,   0,   1'b0, 1};
      vecs[4] = '{"mod1",         16'd77,  16'd5,  16'd1,   0,   1'b0, 5};
      vecs[5] = '{"max_ops",      16'hFFFF, 16'hFFFF, 16'hFFFB, refModexp(16'hFFFF, 16'hFFFF, 16'hFFFB), 1'b0, 32};

      reset = 1'b1;
      start = 1'b0;
      base = '0;
      exponent = '0;
      modulus = '0;
      repeat (3) @(negedge clk);
      checkOutput("reset_flags", {busy, done, error, mod_ready}, 4'b0000);
      checkOutput("reset_result", result, 0);
      checkOutput("reset_numerator", mod_numerator, 0);
      checkOutput("reset_denominator", mod_denominator, 0);
      reset = 1'b0;

      foreach (vecs[i])
         runTransaction(vecs[i].name, vecs[i].b, vecs[i].e, vecs[i].m,
                        vecs[i].exp_r, vecs[i].exp_er, vecs[i].exp_reqs);

      // Modulus zero: immediate error, no requests
      req_base = req_count;
      applyStimulus(16'd5, 16'd7, 16'd0);
      waitDone(r, er, cycles);
      checkOutput("mod0_latency_ok", cycles <= 1, 1);
      checkOutput("mod0_error", er, 1);
      checkOutput("mod0_result", r, 0);
      checkOutput("mod0_requests", req_count - req_base, 0);

      // Second start while busy must be ignored
      req_base = req_count;
      applyStimulus(16'd5, 16'd3, 16'd13);
      @(negedge clk);
      base = 16'd2;
      exponent = 16'd2;
      modulus = 16'd11;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      waitDone(r, er, cycles);
      checkOutput("ignored_start_result", r, 8);
      checkOutput("ignored_start_requests", req_count - req_base, 4);
      repeat (4) @(negedge clk);
      checkOutput("result_held", result, 8);

      // Reset while waiting on the modular unit aborts cleanly
      req_base = req_count;
      applyStimulus(16'd2, 16'd10, 16'd1000);
      for (int i = 0; i < 500 && !(mod_ready && req_count - req_base >= 2); i++) @(negedge clk);
      checkOutput("abort_reached_wait", mod_ready, 1);
      reset = 1'b1;
      @(negedge clk);
      checkOutput("abort_flags", {mod_ready, busy, done}, 3'b000);
      reset = 1'b0;
      saw_done = 0;
      req_base = req_count;
      repeat (30) begin
         @(negedge clk);
         if (done) saw_done = 1;
      end
      checkOutput("abort_no_done", saw_done, 0);
      checkOutput("abort_no_requests", req_count - req_base, 0);
      runTransaction("restart", 16'd2, 16'd10, 16'd1000, 24, 1'b0, 6);

      // Random operands against the reference model
      for (int t = 0; t < 40; t++) begin
         int sel = $urandom_range(0, 9);
         b = OP_W'($urandom);
         e = (sel < 3) ? OP_W'($urandom_range(0, 15)) : OP_W'($urandom);
         m = (sel == 0) ? 16'd0 : (sel == 1) ? 16'd1 : OP_W'($urandom_range(2, 65535));
         runTransaction("random", b, e, m, refModexp(b, e, m), (m == 0), refReqs(e, m));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
